// File: rtl/axi_slv_rsp_model.sv
// -----------------------------------------------------------------------------
// axi_slv_rsp_model
//
// Purpose: AXI slave response model. It sinks write bursts (AW/W) and returns
// one B response for each burst. It accepts read requests (AR) and returns R
// bursts with a self-describing data pattern. Ready gating is either always
// open or driven from a 16-bit LFSR with an adjustable duty. Any transaction
// can be marked for SLVERR at its address handshake. A sticky flag records
// W bursts whose WLAST does not match the AWLEN beat count.
//
// Ports:
//   aclk, aresetn              clock, synchronous active-low reset
//   aw*/err_inj_wr             write address channel plus error-inject flag
//   w*                         write data channel (wdata is discarded)
//   b*                         write response channel
//   ar*/err_inj_rd             read address channel plus error-inject flag
//   r*                         read data channel
//   wr_ostd_cnt, rd_ostd_cnt   outstanding write / read transactions
//   proto_err                  sticky WLAST/AWLEN mismatch flag
// -----------------------------------------------------------------------------
module axi_slv_rsp_model #(
  parameter int          AXI_ID_W   = 4,
  parameter int          AXI_DATA_W = 32,
  parameter int          LEN_W      = 8,
  parameter int          WR_OSTD    = 4,
  parameter int          RD_OSTD    = 4,
  parameter int          READY_MODE = 0,
  parameter int          READY_DUTY = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [AXI_ID_W-1:0]        awid,
  input  logic [LEN_W-1:0]           awlen,
  input  logic                       err_inj_wr,
  input  logic                       wvalid,
  output logic                       wready,
  input  logic [AXI_DATA_W-1:0]      wdata,
  input  logic                       wlast,
  output logic                       bvalid,
  input  logic                       bready,
  output logic [AXI_ID_W-1:0]        bid,
  output logic [1:0]                 bresp,
  input  logic                       arvalid,
  output logic                       arready,
  input  logic [AXI_ID_W-1:0]        arid,
  input  logic [LEN_W-1:0]           arlen,
  input  logic                       err_inj_rd,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [AXI_ID_W-1:0]        rid,
  output logic [AXI_DATA_W-1:0]      rdata,
  output logic [1:0]                 rresp,
  output logic                       rlast,
  output logic [$clog2(WR_OSTD):0]   wr_ostd_cnt,
  output logic [$clog2(RD_OSTD):0]   rd_ostd_cnt,
  output logic                       proto_err
);

  localparam int WP_W   = $clog2(WR_OSTD);
  localparam int RP_W   = $clog2(RD_OSTD);
  localparam int WC_W   = WP_W + 1;
  localparam int RC_W   = RP_W + 1;
  localparam int RSEQ_W = AXI_DATA_W - AXI_ID_W - 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ---------------- ready gating ----------------
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic        aw_gate_q, w_gate_q, ar_gate_q;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lfsr_q    <= LFSR_SEED;
      aw_gate_q <= 1'b0;
      w_gate_q  <= 1'b0;
      ar_gate_q <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      if (READY_MODE == 0) begin
        aw_gate_q <= 1'b1;
        w_gate_q  <= 1'b1;
        ar_gate_q <= 1'b1;
      end else begin
        // 5-bit compare so that a duty of 16 opens the gate every cycle
        aw_gate_q <= {1'b0, lfsr_q[3:0]}  < 5'(READY_DUTY);
        w_gate_q  <= {1'b0, lfsr_q[7:4]}  < 5'(READY_DUTY);
        ar_gate_q <= {1'b0, lfsr_q[11:8]} < 5'(READY_DUTY);
      end
    end
  end

  // ---------------- storage ----------------
  logic [AXI_ID_W-1:0] aw_id_mem  [WR_OSTD];
  logic [LEN_W-1:0]    aw_len_mem [WR_OSTD];
  logic                aw_err_mem [WR_OSTD];
  logic [AXI_ID_W-1:0] b_id_mem   [WR_OSTD];
  logic                b_err_mem  [WR_OSTD];
  logic [AXI_ID_W-1:0] ar_id_mem  [RD_OSTD];
  logic [LEN_W-1:0]    ar_len_mem [RD_OSTD];
  logic                ar_err_mem [RD_OSTD];

  logic [WP_W-1:0]   aw_wp_q, aw_wp_d, aw_rp_q, aw_rp_d;
  logic [WP_W-1:0]   b_wp_q, b_wp_d, b_rp_q, b_rp_d;
  logic [RP_W-1:0]   ar_wp_q, ar_wp_d, ar_rp_q, ar_rp_d;
  logic [WC_W-1:0]   aw_cnt_q, aw_cnt_d, b_cnt_q, b_cnt_d;
  logic [RC_W-1:0]   ar_cnt_q, ar_cnt_d;
  logic [LEN_W-1:0]  beat_q, beat_d, rbeat_q, rbeat_d;
  logic [RSEQ_W-1:0] rseq_q, rseq_d;
  logic              proto_err_q, proto_err_d;

  logic aw_full, aw_empty, b_full, b_empty, ar_full, ar_empty;
  logic aw_push, aw_pop, w_hs, w_last_beat, b_pop, ar_push, ar_pop, r_hs, r_last_beat;
  logic unused_wdata;

  assign unused_wdata = ^wdata;

  // Full/empty from occupancy counts; a same-cycle pop never frees a slot.
  assign aw_full  = aw_cnt_q == WC_W'(WR_OSTD);
  assign aw_empty = aw_cnt_q == '0;
  assign b_full   = b_cnt_q == WC_W'(WR_OSTD);
  assign b_empty  = b_cnt_q == '0;
  assign ar_full  = ar_cnt_q == RC_W'(RD_OSTD);
  assign ar_empty = ar_cnt_q == '0;

  assign awready     = aw_gate_q && !aw_full;
  assign aw_push     = awvalid && awready;
  // W is only accepted against a pending AW and with room for its response
  assign wready      = w_gate_q && !aw_empty && !b_full;
  assign w_hs        = wvalid && wready;
  assign w_last_beat = beat_q == aw_len_mem[aw_rp_q];
  assign aw_pop      = w_hs && w_last_beat;
  assign b_pop       = bvalid && bready;
  assign arready     = ar_gate_q && !ar_full;
  assign ar_push     = arvalid && arready;
  assign r_hs        = rvalid && rready;
  assign r_last_beat = rbeat_q == ar_len_mem[ar_rp_q];
  assign ar_pop      = r_hs && r_last_beat;

  always_comb begin
    aw_wp_d     = aw_wp_q;
    aw_rp_d     = aw_rp_q;
    b_wp_d      = b_wp_q;
    b_rp_d      = b_rp_q;
    ar_wp_d     = ar_wp_q;
    ar_rp_d     = ar_rp_q;
    beat_d      = beat_q;
    rbeat_d     = rbeat_q;
    aw_cnt_d    = aw_cnt_q + WC_W'(aw_push) - WC_W'(aw_pop);
    b_cnt_d     = b_cnt_q + WC_W'(aw_pop) - WC_W'(b_pop);
    ar_cnt_d    = ar_cnt_q + RC_W'(ar_push) - RC_W'(ar_pop);
    rseq_d      = rseq_q + RSEQ_W'(r_hs);
    // the burst is still closed on the counted beat, whatever wlast says
    proto_err_d = proto_err_q | (w_hs && (wlast != w_last_beat));
    if (aw_push) aw_wp_d = aw_wp_q + 1'b1;
    if (aw_pop)  aw_rp_d = aw_rp_q + 1'b1;
    if (aw_pop)  b_wp_d  = b_wp_q + 1'b1;
    if (b_pop)   b_rp_d  = b_rp_q + 1'b1;
    if (ar_push) ar_wp_d = ar_wp_q + 1'b1;
    if (ar_pop)  ar_rp_d = ar_rp_q + 1'b1;
    if (w_hs)    beat_d  = w_last_beat ? '0 : beat_q + 1'b1;
    if (r_hs)    rbeat_d = r_last_beat ? '0 : rbeat_q + 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_wp_q     <= '0;
      aw_rp_q     <= '0;
      b_wp_q      <= '0;
      b_rp_q      <= '0;
      ar_wp_q     <= '0;
      ar_rp_q     <= '0;
      aw_cnt_q    <= '0;
      b_cnt_q     <= '0;
      ar_cnt_q    <= '0;
      beat_q      <= '0;
      rbeat_q     <= '0;
      rseq_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      aw_wp_q     <= aw_wp_d;
      aw_rp_q     <= aw_rp_d;
      b_wp_q      <= b_wp_d;
      b_rp_q      <= b_rp_d;
      ar_wp_q     <= ar_wp_d;
      ar_rp_q     <= ar_rp_d;
      aw_cnt_q    <= aw_cnt_d;
      b_cnt_q     <= b_cnt_d;
      ar_cnt_q    <= ar_cnt_d;
      beat_q      <= beat_d;
      rbeat_q     <= rbeat_d;
      rseq_q      <= rseq_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Entry arrays carry no reset; outputs are masked while the FIFOs are empty.
  always_ff @(posedge aclk) begin
    if (aw_push) begin
      aw_id_mem[aw_wp_q]  <= awid;
      aw_len_mem[aw_wp_q] <= awlen;
      aw_err_mem[aw_wp_q] <= err_inj_wr;
    end
    if (aw_pop) begin
      b_id_mem[b_wp_q]  <= aw_id_mem[aw_rp_q];
      b_err_mem[b_wp_q] <= aw_err_mem[aw_rp_q];
    end
    if (ar_push) begin
      ar_id_mem[ar_wp_q]  <= arid;
      ar_len_mem[ar_wp_q] <= arlen;
      ar_err_mem[ar_wp_q] <= err_inj_rd;
    end
  end

  // ---------------- response outputs ----------------
  assign bvalid = !b_empty;
  assign bid    = bvalid ? b_id_mem[b_rp_q] : '0;
  assign bresp  = (bvalid && b_err_mem[b_rp_q]) ? RESP_SLVERR : RESP_OKAY;

  assign rvalid = !ar_empty;
  assign rid    = rvalid ? ar_id_mem[ar_rp_q] : '0;
  assign rresp  = (rvalid && ar_err_mem[ar_rp_q]) ? RESP_SLVERR : RESP_OKAY;
  assign rlast  = rvalid && r_last_beat;
  assign rdata  = rvalid ? {ar_id_mem[ar_rp_q], 8'(rbeat_q), rseq_q} : '0;

  // A write is outstanding in either the AW FIFO or the B FIFO, so the total
  // can reach 2*WR_OSTD; that single overflow value saturates at all-ones.
  logic [WC_W:0] wr_ostd_sum;
  assign wr_ostd_sum = {1'b0, aw_cnt_q} + {1'b0, b_cnt_q};
  assign wr_ostd_cnt = wr_ostd_sum[WC_W] ? '1 : wr_ostd_sum[WC_W-1:0];
  assign rd_ostd_cnt = ar_cnt_q;
  assign proto_err   = proto_err_q;

endmodule

// File: doc/axi_slv_rsp_model.md
# axi_slv_rsp_model

Parametrised AXI slave response model for the testbench. It accepts write bursts (AW/W) and returns B responses, and accepts read requests (AR) and returns R bursts. Outstanding depth, ID, length and data widths are parametrised. Ready generation is deterministic and LFSR-based, with an adjustable duty. Error injection is per transaction, and a sticky protocol checker flags WLAST/AWLEN mismatches.

## Interface
- AXI_ID_W, 4, ID width
- AXI_DATA_W, 32, read/write data width (≥16)
- LEN_W, 8, burst length field width (beats = len+1)
- WR_OSTD, 4, write outstanding depth (AW FIFO and B FIFO each); power of 2, ≥2
- RD_OSTD, 4, read outstanding depth (AR FIFO); power of 2, ≥2
- READY_MODE, 0, 0 = ready gates always 1; 1 = LFSR-gated
- READY_DUTY, 8, 0..16; in LFSR mode a gate is open when its 4-bit LFSR slice < READY_DUTY
- LFSR_SEED, 16'hACE1, reset value of 16-bit Fibonacci LFSR (taps 16,14,13,11); must be nonzero
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  **synchronous, active-low** reset
- awvalid/awready  in/out  1  AW handshake
- awid, awlen  in  AXI_ID_W, LEN_W  write request ID and length
- wvalid/wready  in/out  1  W handshake
- wdata  in  AXI_DATA_W  ignored (sink)
- wlast  in  1  last write beat
- bvalid/bready  out/in  1  B handshake
- bid, bresp  out  AXI_ID_W, 2  write response ID and response
- arvalid/arready  in/out  1  AR handshake
- arid, arlen  in  AXI_ID_W, LEN_W  read request ID and length
- rvalid/rready  out/in  1  R handshake
- rid, rdata, rresp, rlast  out  AXI_ID_W, AXI_DATA_W, 2, 1  read data channel
- err_inj_wr, err_inj_rd  in  1  sampled at AW / AR handshake; that transaction responds SLVERR (2'b10)
- wr_ostd_cnt  out  $clog2(WR_OSTD)+1  AW entries not yet completed by B handshake
- rd_ostd_cnt  out  $clog2(RD_OSTD)+1  AR entries not yet completed by last R handshake
- proto_err  out  1  sticky; set on WLAST/AWLEN mismatch

## Operation
- **Reset** (aresetn=0 at edge): all FIFOs empty; counters 0; LFSR=LFSR_SEED; proto_err=0. All ready/valid outputs are 0 in the cycle after reset; data outputs are 0.
- **LFSR**: advances every cycle out of reset. Gate bits: aw_gate=lfsr[3:0]<DUTY, w_gate=lfsr[7:4]<DUTY, ar_gate=lfsr[11:8]<DUTY. All gates are 1 when READY_MODE=0. Gates are registered.
- **AW FIFO** (WR_OSTD entries of {id,len,err}): awready = aw_gate && !aw_full. A pop in the same cycle does not free space: full blocks push regardless of pop.
- **W path**: wready = w_gate && !aw_empty && !b_full (AW-before-W; W with no pending AW is stalled). The beat counter (LEN_W bits) counts accepted beats of the head burst.
  - A beat is last when beat_cnt == head.len. On that beat: pop AW, push {id,err} into the B FIFO, clear beat_cnt.
  - If wlast ≠ (beat_cnt == head.len) on any accepted beat, set proto_err. The burst is still closed on the counted last beat.
- **B FIFO** (WR_OSTD entries): bvalid = !b_empty. bid = head id; bresp = err ? 2'b10 : 2'b00. Pop on bvalid&&bready. Head is stable while bvalid&&!bready.
- **AR FIFO** (RD_OSTD entries of {id,len,err}): arready = ar_gate && !ar_full. Full blocks push even when popping.
- **R path**: rvalid = !ar_empty. rid = head id; rresp = err ? 2'b10 : 2'b00; rlast = (rbeat_cnt == head.len).
  - rdata = {head id, rbeat_cnt[7:0], rseq[AXI_DATA_W-AXI_ID_W-9:0]}, where rseq is a global beat counter that increments on each R handshake and wraps.
  - On rvalid&&rready: rbeat_cnt++. If rlast, pop AR and clear rbeat_cnt.
  - Bursts are returned in AR order with no interleave.
- **Outstanding counts**:
  - wr_ostd_cnt: +1 on AW handshake, −1 on B handshake, unchanged when both occur.
  - rd_ostd_cnt: +1 on AR handshake, −1 on rlast handshake, unchanged when both occur.
- **Pointers**: $clog2(depth) bits wide, natural wrap. Full/empty come from a count register, not pointer compare.

## Timing
- Min AW→B latency: a 1-beat burst accepted the cycle after AW gives bvalid the cycle after the last W handshake (1 cycle).
- Min AR→R latency: rvalid is asserted the cycle after the AR handshake.
- All outputs are register- or FIFO-state-driven. There is no combinational path from any input to any output.
- Valid outputs hold, with stable payload, until handshake (AXI rule).
- Reset asserted mid-burst: the next edge discards all state. Partial bursts are not completed, and outputs return to reset values.

## Test plan
- READY_MODE=0, AW id=3 len=3 plus 4 W beats with wlast on beat 4 → exactly one B: bid=3, bresp=00, 5 cycles after AW; proto_err=0.
- AR id=5 len=2, err_inj_rd=1, rready=1 → 3 R beats, rid=5, rresp=10, rlast on the 3rd only; rdata[7:0] seq 0,1,2 from reset.
- Issue WR_OSTD+1 AWs with bready=0 and no W → awready drops after WR_OSTD accepts; wr_ostd_cnt=WR_OSTD; W then fills the B FIFO and wready drops.
- wlast asserted on beat 2 of a len=3 burst → proto_err=1 and sticky; B still issued after beat 4.
- READY_MODE=1, DUTY=8, 1000 random back-to-back ARs/AWs → all responses delivered in order with correct counts; identical ready traces across two runs with the same seed.
- aresetn pulsed low mid R burst → next cycle rvalid=0 and rd_ostd_cnt=0; a new AR completes normally.
